priv_trap_ctrl: RTL and testbench

//  Parametrised privileged-register and trap controller; successor of the fixed rm0-rm4 block.

---
 rtl/priv_trap_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_priv_trap_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_trap_ctrl.sv
// -----------------------------------------------------------------------------
// priv_trap_ctrl
//
// Privileged-register file and trap controller. Holds NUM_RM machine registers,
// takes synchronous exceptions and a maskable level interrupt, computes a
// direct or vectored handler address, and issues a held PC-redirect request to
// fetch with a valid/ack handshake. A trap taken while a trap is already being
// serviced (IN_TRAP=1) is a double fault and halts the core until reset.
//
// Register map:
//   rm0 EPC, rm1 fault address, rm2 cause-specific info, rm3 cause,
//   rm4 status   [0] SUP  [1] PREV_SUP  [2] IE  [3] IN_TRAP
//   rm5 trap base, bit 0 selects vectored mode; rm6 and above are scratch.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_rd_idx/out_rd_data combinational rm read port (0 when idx >= NUM_RM)
//   in_write_enable, in_wr_idx, in_write_data   rm write port
//   in_exception_vector   synchronous exception cause (0 = none)
//   in_fault_pc, in_fault_addr, in_additional_info  trap context
//   in_irq                level interrupt request, gated by IE
//   in_iret               return-from-trap strobe
//   in_redirect_ack       fetch accepted the redirect
//   out_redirect_valid/out_redirect_pc  held redirect request and target
//   out_exception_vector  cause of the last trap taken
//   out_supervisor_mode   rm4[0]
//   out_halt              double fault, sticky until reset
//   out_rm1               rm1 (fault address)
// -----------------------------------------------------------------------------
module priv_trap_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              NUM_RM       = 8,
    parameter int              CAUSE_W      = 3,
    parameter int              IRQ_CAUSE    = 7,
    parameter int              PRIV_CAUSE   = 6,
    parameter logic [XLEN-1:0] RESET_EPC    = 'h1000,
    parameter logic [XLEN-1:0] HANDLER_BASE = 'h2000,
    localparam int             IDX_W        = $clog2(NUM_RM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   in_rd_idx,
    output logic [XLEN-1:0]    out_rd_data,
    input  logic               in_write_enable,
    input  logic [IDX_W-1:0]   in_wr_idx,
    input  logic [XLEN-1:0]    in_write_data,
    input  logic [CAUSE_W-1:0] in_exception_vector,
    input  logic [XLEN-1:0]    in_fault_pc,
    input  logic [XLEN-1:0]    in_fault_addr,
    input  logic [XLEN-1:0]    in_additional_info,
    input  logic               in_irq,
    input  logic               in_iret,
    input  logic               in_redirect_ack,
    output logic               out_redirect_valid,
    output logic [XLEN-1:0]    out_redirect_pc,
    output logic [CAUSE_W-1:0] out_exception_vector,
    output logic               out_supervisor_mode,
    output logic               out_halt,
    output logic [XLEN-1:0]    out_rm1
);

    // Register indices
    localparam int RM_EPC    = 0;
    localparam int RM_ADDR   = 1;
    localparam int RM_INFO   = 2;
    localparam int RM_CAUSE  = 3;
    localparam int RM_STATUS = 4;
    localparam int RM_BASE   = 5;

    // Status bit positions inside rm4
    localparam int S_SUP      = 0;
    localparam int S_PREV_SUP = 1;
    localparam int S_IE       = 2;
    localparam int S_IN_TRAP  = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   rm_reg  [NUM_RM];
    logic [XLEN-1:0]   rm_next [NUM_RM];
    logic [XLEN-1:0]   redirect_pc_reg, redirect_pc_next;
    logic [CAUSE_W-1:0] cause_reg, cause_next;

    logic [XLEN-1:0]   status;
    logic [XLEN-1:0]   trap_base;
    logic [XLEN-1:0]   trap_target;

    // Decoded event for the current RUN cycle (only one wins)
    logic              ev_trap;
    logic [CAUSE_W-1:0] ev_cause;
    logic [XLEN-1:0]   ev_addr;
    logic [XLEN-1:0]   ev_info;
    logic              ev_iret;
    logic              ev_write;

    assign status = rm_reg[RM_STATUS];

    // -------------------------------------------------------------------------
    // Register file storage. Each register has its own reset value, so the
    // flops are generated per entry rather than mapped to a memory.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RM; gi++) begin : g_rm
        localparam logic [XLEN-1:0] RST_VAL =
            (gi == RM_EPC)    ? RESET_EPC :
            (gi == RM_STATUS) ? XLEN'(1) :
            (gi == RM_BASE)   ? HANDLER_BASE : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                rm_reg[gi] <= RST_VAL;
            end else begin
                rm_reg[gi] <= rm_next[gi];
            end
        end
    end

    // Combinational read port; indices past the implemented range read 0.
    always_comb begin
        out_rd_data = '0;
        if (int'(in_rd_idx) < NUM_RM) begin
            out_rd_data = rm_reg[in_rd_idx];
        end
    end

    // -------------------------------------------------------------------------
    // Event priority decode: exception > enabled irq > iret > rm write.
    // A user-mode rm write becomes a privilege trap whose fault address is the
    // register index it tried to touch.
    // -------------------------------------------------------------------------
    always_comb begin
        ev_trap  = 1'b0;
        ev_cause = '0;
        ev_addr  = '0;
        ev_info  = '0;
        ev_iret  = 1'b0;
        ev_write = 1'b0;
        if (in_exception_vector != '0) begin
            ev_trap  = 1'b1;
            ev_cause = in_exception_vector;
            ev_addr  = in_fault_addr;
            ev_info  = in_additional_info;
        end else if (in_irq && status[S_IE]) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_W'(IRQ_CAUSE);
        end else if (in_iret) begin
            ev_iret = 1'b1;
        end else if (in_write_enable) begin
            if (status[S_SUP]) begin
                ev_write = (int'(in_wr_idx) < NUM_RM);
            end else begin
                ev_trap  = 1'b1;
                ev_cause = CAUSE_W'(PRIV_CAUSE);
                ev_addr  = XLEN'(in_wr_idx);
                ev_info  = in_additional_info;
            end
        end
    end

    // Handler address: the base is word aligned; vectored mode adds 4 bytes
    // per cause code and simply wraps on overflow.
    assign trap_base   = {rm_reg[RM_BASE][XLEN-1:2], 2'b00};
    assign trap_target = rm_reg[RM_BASE][0] ? (trap_base + (XLEN'(ev_cause) << 2))
                                            : trap_base;

    // -------------------------------------------------------------------------
    // Next-state and register update
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        cause_next       = cause_reg;
        for (int i = 0; i < NUM_RM; i++) begin
            rm_next[i] = rm_reg[i];
        end

        case (state_reg)
            ST_RUN: begin
                if (ev_trap) begin
                    if (status[S_IN_TRAP]) begin
                        // Double fault: freeze everything, no redirect.
                        state_next = ST_HALT;
                    end else begin
                        rm_next[RM_EPC]              = in_fault_pc;
                        rm_next[RM_ADDR]             = ev_addr;
                        rm_next[RM_INFO]             = ev_info;
                        rm_next[RM_CAUSE]            = XLEN'(ev_cause);
                        rm_next[RM_STATUS][S_SUP]      = 1'b1;
                        rm_next[RM_STATUS][S_PREV_SUP] = status[S_SUP];
                        rm_next[RM_STATUS][S_IE]       = 1'b0;
                        rm_next[RM_STATUS][S_IN_TRAP]  = 1'b1;
                        cause_next       = ev_cause;
                        redirect_pc_next = trap_target;
                        state_next       = ST_REDIR;
                    end
                end else if (ev_iret) begin
                    rm_next[RM_STATUS][S_SUP]     = status[S_PREV_SUP];
                    rm_next[RM_STATUS][S_IE]      = 1'b1;
                    rm_next[RM_STATUS][S_IN_TRAP] = 1'b0;
                    redirect_pc_next = rm_reg[RM_EPC];
                    state_next       = ST_REDIR;
                end else if (ev_write) begin
                    rm_next[in_wr_idx] = in_write_data;
                end
            end
            ST_REDIR: begin
                // Pipeline is flushing: only the acknowledge matters here.
                if (in_redirect_ack) begin
                    state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            redirect_pc_reg <= '0;
            cause_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            redirect_pc_reg <= redirect_pc_next;
            cause_reg       <= cause_next;
        end
    end

    assign out_redirect_valid   = (state_reg == ST_REDIR);
    assign out_redirect_pc      = redirect_pc_reg;
    assign out_exception_vector = cause_reg;
    assign out_supervisor_mode  = status[S_SUP];
    assign out_halt             = (state_reg == ST_HALT);
    assign out_rm1              = rm_reg[RM_ADDR];

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_priv_trap_ctrl
//
// Self-checking bench for priv_trap_ctrl (default parameters). A table of
// directed cycle vectors walks through exception, vectored irq, iret to user,
// privilege trap, same-cycle priority and double fault; hand sequences cover
// reset values, latency, halt release and reset during a pending redirect;
// a randomized phase compares every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_priv_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;
    logic        write_enable;
    logic [2:0]  wr_idx;
    logic [31:0] write_data;
    logic [2:0]  exc;
    logic [31:0] fault_pc;
    logic [31:0] fault_addr;
    logic [31:0] add_info;
    logic        irq;
    logic        iret;
    logic        ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  exc_out;
    logic        sup_mode;
    logic        halt;
    logic [31:0] rm1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priv_trap_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .in_rd_idx            (rd_idx),
        .out_rd_data          (rd_data),
        .in_write_enable      (write_enable),
        .in_wr_idx            (wr_idx),
        .in_write_data        (write_data),
        .in_exception_vector  (exc),
        .in_fault_pc          (fault_pc),
        .in_fault_addr        (fault_addr),
        .in_additional_info   (add_info),
        .in_irq               (irq),
        .in_iret              (iret),
        .in_redirect_ack      (ack),
        .out_redirect_valid   (redirect_valid),
        .out_redirect_pc      (redirect_pc),
        .out_exception_vector (exc_out),
        .out_supervisor_mode  (sup_mode),
        .out_halt             (halt),
        .out_rm1              (rm1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rd_idx = 3'd0; write_enable = 1'b0; wr_idx = 3'd0; write_data = 32'd0;
        exc = 3'd0; fault_pc = 32'd0; fault_addr = 32'd0; add_info = 32'd0;
        irq = 1'b0; iret = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] exc, fpc, faddr, info, irq, iret, we, widx, wdata, ack, rd;
        logic [31:0] e_valid, e_pc, e_halt, e_sup, e_cause, e_rm1, e_rd;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_rm [8];
    logic        m_pend, m_halt;
    logic [31:0] m_pc;
    logic [2:0]  m_cause;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_rm[i] = 32'd0;
        m_rm[0] = 32'h1000;
        m_rm[4] = 32'd1;
        m_rm[5] = 32'h2000;
        m_pend = 1'b0; m_halt = 1'b0; m_pc = 32'd0; m_cause = 3'd0;
    endfunction

    // One clock of architectural behaviour, from the current tb input values.
    function automatic void model_step();
        logic        sup, ie, in_trap, trap;
        logic [2:0]  c;
        logic [31:0] a, inf, base;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_halt) return;
        if (m_pend) begin
            if (ack) m_pend = 1'b0;
            return;
        end
        sup = m_rm[4][0]; ie = m_rm[4][2]; in_trap = m_rm[4][3];
        trap = 1'b0; c = 3'd0; a = 32'd0; inf = 32'd0;
        if (exc != 3'd0) begin
            trap = 1'b1; c = exc; a = fault_addr; inf = add_info;
        end else if (irq && ie) begin
            trap = 1'b1; c = 3'd7;
        end else if (iret) begin
            m_rm[4][0] = m_rm[4][1];
            m_rm[4][2] = 1'b1;
            m_rm[4][3] = 1'b0;
            m_pc = m_rm[0];
            m_pend = 1'b1;
        end else if (write_enable) begin
            if (sup) m_rm[wr_idx] = write_data;
            else begin
                trap = 1'b1; c = 3'd6; a = {29'd0, wr_idx}; inf = add_info;
            end
        end
        if (trap) begin
            if (in_trap) m_halt = 1'b1;
            else begin
                base = m_rm[5] & 32'hFFFF_FFFC;
                m_pc = m_rm[5][0] ? base + 32'(c) * 32'd4 : base;
                m_rm[0] = fault_pc; m_rm[1] = a; m_rm[2] = inf; m_rm[3] = {29'd0, c};
                m_rm[4][1] = sup; m_rm[4][0] = 1'b1; m_rm[4][2] = 1'b0; m_rm[4][3] = 1'b1;
                m_cause = c;
                m_pend = 1'b1;
            end
        end
    endfunction

    initial begin
        vec[0]  = '{3,'h40,'hAA,'hBB,0,0,0,0,0,0,3,        1,'h2000,0,1,3,'hAA,3};
        vec[1]  = '{0,0,0,0,0,0,0,0,0,0,0,                 1,'h2000,0,1,3,'hAA,'h40};
        vec[2]  = '{0,0,0,0,0,1,0,0,0,0,4,                 1,'h2000,0,1,3,'hAA,'hB};
        vec[3]  = '{0,0,0,0,0,0,0,0,0,1,1,                 0,'h2000,0,1,3,'hAA,'hAA};
        vec[4]  = '{0,0,0,0,0,0,1,5,'h2001,0,5,            0,'h2000,0,1,3,'hAA,'h2001};
        vec[5]  = '{0,0,0,0,0,1,0,0,0,0,4,                 1,'h40,0,1,3,'hAA,7};
        vec[6]  = '{0,0,0,0,0,0,0,0,0,1,2,                 0,'h40,0,1,3,'hAA,'hBB};
        vec[7]  = '{0,'h300,'h55,'h99,1,0,0,0,0,0,0,       1,'h201C,0,1,7,0,'h300};
        vec[8]  = '{0,0,0,0,0,0,0,0,0,1,4,                 0,'h201C,0,1,7,0,'hB};
        vec[9]  = '{0,0,0,0,0,0,1,4,9,0,4,                 0,'h201C,0,1,7,0,9};
        vec[10] = '{0,0,0,0,0,1,0,0,0,0,4,                 1,'h300,0,0,7,0,4};
        vec[11] = '{0,0,0,0,0,0,0,0,0,1,2,                 0,'h300,0,0,7,0,0};
        vec[12] = '{0,'h500,0,'h77,0,0,1,6,'h1234,0,6,     1,'h2018,0,1,6,6,0};
        vec[13] = '{0,0,0,0,0,0,0,0,0,1,3,                 0,'h2018,0,1,6,6,6};
        vec[14] = '{0,0,0,0,0,1,0,0,0,0,0,                 1,'h500,0,0,6,6,'h500};
        vec[15] = '{0,0,0,0,0,0,0,0,0,1,2,                 0,'h500,0,0,6,6,'h77};
        vec[16] = '{2,'h600,'h66,'h88,1,1,1,7,'hDEAD,0,7,  1,'h2008,0,1,2,'h66,0};
        vec[17] = '{5,'h700,'h11,0,0,0,0,0,0,0,3,          1,'h2008,0,1,2,'h66,2};
        vec[18] = '{0,0,0,0,0,0,0,0,0,1,4,                 0,'h2008,0,1,2,'h66,9};
        vec[19] = '{4,'h800,'h22,0,0,0,0,0,0,0,0,          0,'h2008,1,1,2,'h66,'h600};
        vec[20] = '{0,0,0,0,1,1,1,0,'hFFFF,1,4,            0,'h2008,1,1,2,'h66,9};

        // ---- reset values ----
        do_reset();
        chk("reset_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset_halt",  {31'd0, halt}, 32'd0);
        chk("reset_sup",   {31'd0, sup_mode}, 32'd1);
        chk("reset_cause", {29'd0, exc_out}, 32'd0);
        chk("reset_pc",    redirect_pc, 32'd0);
        chk("reset_rm1",   rm1, 32'd0);
        rd_idx = 3'd0; #1;
        chk("reset_rm0", rd_data, 32'h1000);
        rd_idx = 3'd5; #1;
        chk("reset_rm5", rd_data, 32'h2000);
        rd_idx = 3'd4; #1;
        chk("reset_rm4", rd_data, 32'h1);
        $display("reset: rm0/rm4/rm5 and outputs checked");

        // ---- directed table ----
        for (int r = 0; r < NV; r++) begin
            exc = vec[r].exc[2:0]; fault_pc = vec[r].fpc; fault_addr = vec[r].faddr;
            add_info = vec[r].info; irq = vec[r].irq[0]; iret = vec[r].iret[0];
            write_enable = vec[r].we[0]; wr_idx = vec[r].widx[2:0];
            write_data = vec[r].wdata; ack = vec[r].ack[0]; rd_idx = vec[r].rd[2:0];
            if (r == 0) begin
                #1;
                chk("latency_pre_edge_valid", {31'd0, redirect_valid}, 32'd0);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", r), {31'd0, redirect_valid}, vec[r].e_valid);
            chk($sformatf("v%0d_pc", r),    redirect_pc, vec[r].e_pc);
            chk($sformatf("v%0d_halt", r),  {31'd0, halt}, vec[r].e_halt);
            chk($sformatf("v%0d_sup", r),   {31'd0, sup_mode}, vec[r].e_sup);
            chk($sformatf("v%0d_cause", r), {29'd0, exc_out}, vec[r].e_cause);
            chk($sformatf("v%0d_rm1", r),   rm1, vec[r].e_rm1);
            chk($sformatf("v%0d_rd", r),    rd_data, vec[r].e_rd);
            $display("vec %0d: valid=%0b pc=%h halt=%0b sup=%0b cause=%0d rd[%0d]=%h",
                     r, redirect_valid, redirect_pc, halt, sup_mode, exc_out, rd_idx, rd_data);
        end

        // ---- halt cleared by reset ----
        do_reset();
        chk("halt_release_halt",  {31'd0, halt}, 32'd0);
        chk("halt_release_valid", {31'd0, redirect_valid}, 32'd0);
        chk("halt_release_sup",   {31'd0, sup_mode}, 32'd1);
        $display("halt release: halt=%0b valid=%0b", halt, redirect_valid);

        // ---- reset in the middle of a redirect drops the request ----
        exc = 3'd1; fault_pc = 32'h10;
        @(posedge clk); #1;
        clear_inputs();
        chk("midredir_valid", {31'd0, redirect_valid}, 32'd1);
        chk("midredir_pc", redirect_pc, 32'h2000);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midredir_reset_valid", {31'd0, redirect_valid}, 32'd0);
        chk("midredir_reset_pc", redirect_pc, 32'd0);
        chk("midredir_reset_cause", {29'd0, exc_out}, 32'd0);
        $display("reset mid-redirect: valid=%0b pc=%h", redirect_valid, redirect_pc);

        // ---- randomized phase vs. model ----
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            reset        = ($urandom_range(0, 59) == 0);
            exc          = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            irq          = ($urandom_range(0, 3) == 0);
            iret         = ($urandom_range(0, 7) == 0);
            write_enable = ($urandom_range(0, 2) == 0);
            wr_idx       = 3'($urandom_range(0, 7));
            write_data   = (wr_idx == 3'd4) ? 32'($urandom_range(0, 15)) : $urandom;
            fault_pc     = $urandom;
            fault_addr   = $urandom;
            add_info     = $urandom;
            ack          = ($urandom_range(0, 1) == 0);
            rd_idx       = 3'($urandom_range(0, 7));
            #1;
            chk("rand_rd_pre", rd_data, m_rm[rd_idx]);
            model_step();
            @(posedge clk); #1;
            chk("rand_valid", {31'd0, redirect_valid}, {31'd0, m_pend});
            chk("rand_pc",    redirect_pc, m_pc);
            chk("rand_halt",  {31'd0, halt}, {31'd0, m_halt});
            chk("rand_sup",   {31'd0, sup_mode}, {31'd0, m_rm[4][0]});
            chk("rand_cause", {29'd0, exc_out}, {29'd0, m_cause});
            chk("rand_rm1",   rm1, m_rm[1]);
            chk("rand_rd",    rd_data, m_rm[rd_idx]);
            $display("rand %0d: rst=%0b exc=%0d irq=%0b iret=%0b we=%0b ack=%0b -> valid=%0b pc=%h halt=%0b",
                     n, reset, exc, irq, iret, write_enable, ack, redirect_valid, redirect_pc, halt);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
